// File: rtl/gray_sched_pkg.sv
// Shared types and constants for the Gray-code step-counter scheduler.
package gray_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  // Gray value the counter holds just before it wraps to 3'b000.
  localparam logic [2:0] GRAY_WRAP = 3'b100;

  localparam int unsigned STEP_W_DEF = 4;
  localparam int unsigned LAP_W_DEF  = 8;

endpackage

// File: rtl/gray_sched_if.sv
// Request/grant bundle between requesters, the scheduler and the shared counter.
interface gray_sched_if #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned STEP_W = gray_sched_pkg::STEP_W_DEF,
  parameter int unsigned LAP_W  = gray_sched_pkg::LAP_W_DEF
);
  logic [NREQ-1:0]        Req;
  logic [NREQ-1:0]        Clr;
  logic [NREQ*STEP_W-1:0] Steps;
  logic [2:0]             GrayIn;
  logic [NREQ-1:0]        Grant;
  logic [NREQ-1:0]        Done;
  logic                   CntEn;
  logic                   CntClr;
  logic                   Busy;
  logic [LAP_W-1:0]       Laps;

  modport master (
    output Req, Clr, Steps, GrayIn,
    input  Grant, Done, CntEn, CntClr, Busy, Laps
  );

  modport slave (
    input  Req, Clr, Steps, GrayIn,
    output Grant, Done, CntEn, CntClr, Busy, Laps
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr wins.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx
);

  logic          found;
  logic [IW-1:0] k;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    k      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k = IW'((32'(ptr) + i) % NREQ);
      if (!found && req[k]) begin
        found     = 1'b1;
        onehot[k] = 1'b1;
        idx       = k;
      end
    end
  end

endmodule

// File: rtl/gray_sched.sv
// Round-robin owner arbitration for a shared 3-bit Gray step counter,
// with burst sequencing (optional clear, N steps, done pulse) and a wrap counter.
module gray_sched
  import gray_sched_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned STEP_W = STEP_W_DEF,
  parameter int unsigned LAP_W  = LAP_W_DEF
) (
  input logic         Clk,
  input logic         Reset,
  gray_sched_if.slave bus
);

  localparam int unsigned IW = $clog2(NREQ);

  sched_state_t      state, nxt;
  logic [NREQ-1:0]   pick_oh;
  logic [NREQ-1:0]   grant_q;
  logic [IW-1:0]     pick_idx;
  logic [IW-1:0]     ptr;
  logic [STEP_W-1:0] pick_steps;
  logic [STEP_W-1:0] rem;
  logic [LAP_W-1:0]  laps;
  logic              pick_clr;
  logic              any_req;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (bus.Req),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  assign any_req    = |bus.Req;
  assign pick_clr   = bus.Clr[pick_idx];
  assign pick_steps = bus.Steps[32'(pick_idx) * STEP_W +: STEP_W];

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          if (pick_clr)                nxt = CLEAR;
          else if (pick_steps != '0)   nxt = RUN;
          else                         nxt = DONE;
        end
      end
      CLEAR:   nxt = (rem != '0) ? RUN : DONE;
      RUN:     if (rem <= STEP_W'(1)) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      grant_q <= '0;
      ptr     <= '0;
      rem     <= '0;
      laps    <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_q <= pick_oh;
            rem     <= pick_steps;
            ptr     <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
          end
        end
        RUN:     rem <= rem - 1'b1;
        DONE:    grant_q <= '0;
        default: ;
      endcase
      // Cleared on entry to CLEAR so Laps already reads 0 while CntClr is high.
      if (nxt == CLEAR)
        laps <= '0;
      else if (state == RUN && bus.GrayIn == GRAY_WRAP && laps != '1)
        laps <= laps + 1'b1;
    end
  end

  assign bus.Grant  = grant_q;
  assign bus.Done   = (state == DONE) ? grant_q : '0;
  assign bus.CntEn  = (state == RUN);
  assign bus.CntClr = (state == CLEAR);
  assign bus.Busy   = (state != IDLE);
  assign bus.Laps   = laps;

endmodule

// File: tb/tb_gray_sched.sv
// Directed bench for gray_sched: burst vector table plus round-robin, reset and saturation sequences.
module tb_gray_sched;

  localparam int unsigned N  = 4;
  localparam int unsigned SW = 4;
  localparam int unsigned LW = 8;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  gray_sched_if #(.NREQ(N), .STEP_W(SW), .LAP_W(LW)) bus ();
  gray_sched_if #(.NREQ(2), .STEP_W(6), .LAP_W(2))   sbus ();

  gray_sched #(.NREQ(N), .STEP_W(SW), .LAP_W(LW)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus)
  );

  gray_sched #(.NREQ(2), .STEP_W(6), .LAP_W(2)) dut_sat (
    .Clk(Clk), .Reset(Reset), .bus(sbus)
  );

  // Shared counter models: binary count, Gray-coded output, reset by Reset|CntClr.
  logic [2:0] cnt, scnt;
  always_ff @(posedge Clk) begin
    if (Reset || bus.CntClr) cnt <= '0;
    else if (bus.CntEn)      cnt <= cnt + 3'd1;
    if (Reset || sbus.CntClr) scnt <= '0;
    else if (sbus.CntEn)      scnt <= scnt + 3'd1;
  end
  assign bus.GrayIn  = cnt ^ (cnt >> 1);
  assign sbus.GrayIn = scnt ^ (scnt >> 1);

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int unsigned idx;
    logic        clr;
    int unsigned steps;
    int unsigned lat;    // negedge samples after the request edge until Done
    int unsigned en;     // CntEn cycles
    int unsigned clrc;   // CntClr cycles
    int unsigned laps;   // Laps after the burst
    logic [2:0]  gray;   // counter output after the burst
  } vec_t;

  vec_t vecs[6];

  int unsigned  lat, en_n, clr_n, gr_n, busy_n, ng;
  logic         seen;
  logic [N-1:0] dval, onehot, prevg;
  logic [N-1:0] order[5];
  logic [N-1:0] exp_order[5];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1, 1'b0,  5,  6,  5, 0, 0, 3'b111};
    vecs[1] = '{0, 1'b1,  8, 10,  8, 1, 1, 3'b000};
    vecs[2] = '{2, 1'b0,  0,  1,  0, 0, 1, 3'b000};
    vecs[3] = '{3, 1'b1,  0,  2,  0, 1, 0, 3'b000};
    vecs[4] = '{2, 1'b0, 15, 16, 15, 0, 1, 3'b100};
    vecs[5] = '{1, 1'b0,  1,  2,  1, 0, 2, 3'b000};
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    Reset = 1'b1;
    bus.Req = '0;  bus.Clr = '0;  bus.Steps = '0;
    sbus.Req = '0; sbus.Clr = '0; sbus.Steps = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_grant",  int'(bus.Grant),  0);
    check("rst_done",   int'(bus.Done),   0);
    check("rst_cnten",  int'(bus.CntEn),  0);
    check("rst_cntclr", int'(bus.CntClr), 0);
    check("rst_busy",   int'(bus.Busy),   0);
    check("rst_laps",   int'(bus.Laps),   0);
    Reset = 1'b0;

    // Single-requester bursts from the table.
    for (int v = 0; v < 6; v++) begin
      @(negedge Clk);
      onehot = '0;
      onehot[vecs[v].idx] = 1'b1;
      bus.Req = onehot;
      bus.Clr = '0;
      bus.Clr[vecs[v].idx] = vecs[v].clr;
      bus.Steps = '0;
      bus.Steps[vecs[v].idx*SW +: SW] = SW'(vecs[v].steps);
      en_n = 0; clr_n = 0; gr_n = 0; busy_n = 0; lat = 0; seen = 1'b0; dval = '0;
      for (int k = 1; k <= 40 && !seen; k++) begin
        @(negedge Clk);
        if (bus.CntEn)  en_n++;
        if (bus.CntClr) clr_n++;
        if (bus.Busy)   busy_n++;
        if (bus.Grant == onehot) gr_n++;
        if (bus.Done != '0) begin
          seen = 1'b1;
          lat  = k;
          dval = bus.Done;
          bus.Req = '0;
        end
      end
      check($sformatf("v%0d_seen", v), int'(seen), 1);
      check($sformatf("v%0d_lat", v), int'(lat), int'(vecs[v].lat));
      check($sformatf("v%0d_done", v), int'(dval), int'(onehot));
      check($sformatf("v%0d_en", v), int'(en_n), int'(vecs[v].en));
      check($sformatf("v%0d_clr", v), int'(clr_n), int'(vecs[v].clrc));
      check($sformatf("v%0d_grant", v), int'(gr_n), int'(vecs[v].lat));
      check($sformatf("v%0d_busy", v), int'(busy_n), int'(vecs[v].lat));
      @(negedge Clk);
      check($sformatf("v%0d_idle", v), int'(bus.Busy), 0);
      check($sformatf("v%0d_laps", v), int'(bus.Laps), int'(vecs[v].laps));
      check($sformatf("v%0d_gray", v), int'(bus.GrayIn), int'(vecs[v].gray));
    end

    // Reset during RUN abandons the burst; pointer restarts at 0.
    @(negedge Clk);
    bus.Req = 4'b0100;
    bus.Steps = '0;
    bus.Steps[2*SW +: SW] = SW'(10);
    seen = 1'b0;
    for (int k = 0; k < 5 && !seen; k++) begin
      @(negedge Clk);
      if (bus.CntEn) seen = 1'b1;
    end
    check("mid_run", int'(seen), 1);
    Reset = 1'b1;
    @(negedge Clk);
    check("mid_grant",  int'(bus.Grant),  0);
    check("mid_done",   int'(bus.Done),   0);
    check("mid_cnten",  int'(bus.CntEn),  0);
    check("mid_cntclr", int'(bus.CntClr), 0);
    check("mid_busy",   int'(bus.Busy),   0);
    check("mid_laps",   int'(bus.Laps),   0);
    Reset = 1'b0;
    bus.Req = 4'b1001;
    bus.Steps = '0;
    bus.Steps[0 +: SW]    = SW'(1);
    bus.Steps[3*SW +: SW] = SW'(1);
    dval = '0;
    for (int k = 0; k < 5 && dval == '0; k++) begin
      @(negedge Clk);
      dval = bus.Grant;
    end
    check("mid_first", int'(dval), 1);
    seen = 1'b0;
    for (int k = 0; k < 5 && !seen; k++) begin
      if (bus.Done != '0) seen = 1'b1;
      else @(negedge Clk);
    end
    check("mid_done_after", int'(seen), 1);
    bus.Req = '0;
    @(negedge Clk);

    // All four requesters held: order 0,1,2,3,0 with an IDLE gap between owners.
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    bus.Req = 4'b1111;
    bus.Clr = '0;
    bus.Steps = {SW'(2), SW'(2), SW'(2), SW'(2)};
    ng = 0;
    prevg = '0;
    for (int c = 0; c < 100 && ng < 5; c++) begin
      @(negedge Clk);
      if (bus.Grant != '0 && bus.Grant != prevg) begin
        check($sformatf("rr_gap%0d", ng), int'(prevg), 0);
        order[ng] = bus.Grant;
        ng++;
      end
      prevg = bus.Grant;
    end
    check("rr_count", int'(ng), 5);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (bus.Done != '0) seen = 1'b1;
      else @(negedge Clk);
    end
    bus.Req = '0;
    check("rr_last_done", int'(seen), 1);
    for (int i = 0; i < 5; i++)
      check($sformatf("rr_order%0d", i), int'(order[i]), int'(exp_order[i]));
    @(negedge Clk);

    // Two-bit Laps saturates at 3 across five wraps.
    sbus.Req   = 2'b01;
    sbus.Clr   = 2'b01;
    sbus.Steps = '0;
    sbus.Steps[5:0] = 6'd40;
    en_n = 0; lat = 0; seen = 1'b0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge Clk);
      if (sbus.CntEn) en_n++;
      if (sbus.Done != '0) begin
        seen = 1'b1;
        lat  = k;
        sbus.Req = '0;
      end
    end
    check("sat_seen", int'(seen), 1);
    check("sat_lat",  int'(lat), 42);
    check("sat_en",   int'(en_n), 40);
    check("sat_laps", int'(sbus.Laps), 3);
    @(negedge Clk);
    check("sat_hold", int'(sbus.Laps), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
